// File: rtl/bcd_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_conv_arbiter_if
//  Purpose  : Request/grant/result bundle between the two requesters (score
//             and countdown timer) and the shared binary-to-BCD engine.
//  Signals  : req0/bin0, req1/bin1  - requests and operands (master drives)
//             gnt0/gnt1             - one-cycle operand-capture pulses
//             busy                  - conversion in progress
//             done/done_id/bcd_out  - result pulse, owner and packed BCD
//  Modports : master (requesters), slave (conversion engine)
//  Revision : 1.0 - initial release
// ============================================================================
interface bcd_conv_arbiter_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  req0;
   logic [BIN_W-1:0]      bin0;
   logic                  req1;
   logic [BIN_W-1:0]      bin1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  busy;
   logic                  done;
   logic                  done_id;
   logic [4*DIGITS-1:0]   bcd_out;

   modport master (
      output req0, bin0, req1, bin1,
      input  gnt0, gnt1, busy, done, done_id, bcd_out
   );

   modport slave (
      input  req0, bin0, req1, bin1,
      output gnt0, gnt1, busy, done, done_id, bcd_out
   );
endinterface
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_conv_arbiter
//  Purpose  : Iterative double-dabble binary-to-BCD converter shared by two
//             requesters through a round-robin arbiter. One shift/add-3 step
//             per clock; BIN_W steps per conversion.
//  Ports    : clk      - system clock (rising edge)
//             rst      - synchronous active-high reset
//             conv_if  - slave side of bcd_conv_arbiter_if (requests,
//                        operands, grants, busy, done/done_id, bcd_out)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   bcd_conv_arbiter_if.slave      conv_if
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CONV = 1'b1;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIN_W - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic [0:0]        state_q,   state_d;
   logic [BIN_W-1:0]  op_q,      op_d;
   logic [ACC_W-1:0]  acc_q,     acc_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              winner_q,  winner_d;
   // Requester that wins a simultaneous request (the one not served last).
   logic              prio_q,    prio_d;
   logic              gnt0_q,    gnt0_d;
   logic              gnt1_q,    gnt1_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              done_id_q, done_id_d;
   logic [ACC_W-1:0]  bcd_q,     bcd_d;

   logic              w_win;
   logic [ACC_W-1:0]  w_acc_adj;
   logic [ACC_W-1:0]  w_acc_shift;

   // Single request wins outright; a tie goes to the favoured requester.
   assign w_win = (conv_if.req0 && conv_if.req1) ? prio_q : conv_if.req1;

   // Per-nibble add-3 correction; 4-bit adders, no inter-nibble carry.
   for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      assign w_acc_adj[4*i +: 4] = (acc_q[4*i +: 4] > 4'd4) ?
                                   (acc_q[4*i +: 4] + 4'd3) :
                                    acc_q[4*i +: 4];
   end

   // Shift {accumulator, operand} left: operand MSB enters accumulator LSB.
   assign w_acc_shift = {w_acc_adj[ACC_W-2:0], op_q[BIN_W-1]};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      winner_d  = winner_q;
      prio_d    = prio_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      bcd_d     = bcd_q;

      case (state_q)
         S_IDLE: begin
            if (conv_if.req0 || conv_if.req1) begin
               winner_d = w_win;
               op_d     = w_win ? conv_if.bin1 : conv_if.bin0;
               acc_d    = '0;
               cnt_d    = '0;
               gnt0_d   = ~w_win;
               gnt1_d   = w_win;
               busy_d   = 1'b1;
               state_d  = S_CONV;
            end
         end
         S_CONV: begin
            acc_d = w_acc_shift;
            op_d  = {op_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + C_ONE;
            if (cnt_q == C_LAST) begin
               // Last iteration: publish the just-computed accumulator.
               bcd_d     = w_acc_shift;
               done_d    = 1'b1;
               done_id_d = winner_q;
               prio_d    = ~winner_q;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         winner_q  <= 1'b0;
         prio_q    <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         winner_q  <= winner_d;
         prio_q    <= prio_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         bcd_q     <= bcd_d;
      end
   end

   assign conv_if.gnt0    = gnt0_q;
   assign conv_if.gnt1    = gnt1_q;
   assign conv_if.busy    = busy_q;
   assign conv_if.done    = done_q;
   assign conv_if.done_id = done_id_q;
   assign conv_if.bcd_out = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_conv_arbiter
//  Purpose  : Self-checking bench for bcd_conv_arbiter. Expected results are
//             queued when a request is issued and popped on each done pulse.
//  Ports    : none (top level)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

   localparam int BIN_W  = 8;
   localparam int DIGITS = 3;
   localparam int ACC_W  = 4 * DIGITS;

   typedef struct packed {
      logic              id;
      logic [ACC_W-1:0]  bcd;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cyc;
   int   last_gnt_cyc;
   logic exp_busy;
   exp_t sb_q[$];

   bcd_conv_arbiter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bcd_conv_arbiter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .conv_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: digit k from (v / 10^k) % 10.
   function automatic logic [ACC_W-1:0] ref_bcd(input int v);
      logic [ACC_W-1:0] r;
      int               t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Output monitor: overlap rules, busy tracking and scoreboard compare.
   always @(negedge clk) begin
      if (rst) begin
         exp_busy = 1'b0;
      end else begin
         if (bus.gnt0 || bus.gnt1) begin
            exp_busy     = 1'b1;
            last_gnt_cyc = cyc;
         end
         if (bus.done) exp_busy = 1'b0;
         chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
         chk("gnt_overlap", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
         chk("done_with_gnt", {31'd0, bus.done & (bus.gnt0 | bus.gnt1)}, 32'd0);
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("done_id", {31'd0, bus.done_id}, {31'd0, e.id});
               chk("bcd_out", {20'd0, bus.bcd_out}, {20'd0, e.bcd});
               chk("latency", cyc - last_gnt_cyc, BIN_W);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int id, output int n);
      id = -1;
      n  = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         n++;
         if (bus.gnt0 || bus.gnt1) begin
            id = bus.gnt1 ? 1 : 0;
            break;
         end
      end
      if (id < 0) chk("gnt_timeout", 32'd1, 32'd0);
   endtask

   task automatic req_one(input int id, input int val);
      int got, n;
      sb_q.push_back('{id: id[0], bcd: ref_bcd(val)});
      if (id == 0) begin
         bus.bin0 = BIN_W'(val);
         bus.req0 = 1'b1;
      end else begin
         bus.bin1 = BIN_W'(val);
         bus.req1 = 1'b1;
      end
      wait_gnt(got, n);
      chk("gnt_id", got, id);
      if (id == 0) bus.req0 = 1'b0;
      else         bus.req1 = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (sb_q.size() == 0 && !bus.busy) break;
         tick();
      end
      chk("drain", sb_q.size(), 0);
   endtask

   initial begin
      int got, n, c0, c1;
      checks       = 0;
      failures     = 0;
      cyc          = 0;
      last_gnt_cyc = 0;
      exp_busy     = 1'b0;
      rst          = 1'b1;
      bus.req0     = 1'b0;
      bus.req1     = 1'b0;
      bus.bin0     = '0;
      bus.bin1     = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_gnt0",    {31'd0, bus.gnt0},    32'd0);
      chk("rst_gnt1",    {31'd0, bus.gnt1},    32'd0);
      chk("rst_busy",    {31'd0, bus.busy},    32'd0);
      chk("rst_done",    {31'd0, bus.done},    32'd0);
      chk("rst_done_id", {31'd0, bus.done_id}, 32'd0);
      chk("rst_bcd",     {20'd0, bus.bcd_out}, 32'd0);
      rst = 1'b0;
      tick();

      // Single request from idle; gnt on the cycle after capture
      sb_q.push_back('{id: 1'b0, bcd: 12'h123});
      bus.bin0 = 8'd123;
      bus.req0 = 1'b1;
      wait_gnt(got, n);
      chk("gnt_id_123", got, 0);
      chk("gnt_latency", n, 1);
      bus.req0 = 1'b0;
      drain();
      chk("hold_bcd", {20'd0, bus.bcd_out}, 32'h123);

      // Boundary values via requester 1
      req_one(1, 0);
      req_one(1, 255);
      req_one(1, 99);
      req_one(1, 100);
      drain();

      // Both held: grants alternate starting with requester 0
      for (int i = 0; i < 4; i++)
         sb_q.push_back('{id: i[0], bcd: (i[0] ? 12'h200 : 12'h005)});
      bus.bin0 = 8'd5;
      bus.bin1 = 8'd200;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(got, n);
         chk("rr_gnt", got, i % 2);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      drain();

      // Back-to-back on requester 0, captures BIN_W+1 edges apart
      sb_q.push_back('{id: 1'b0, bcd: 12'h017});
      bus.bin0 = 8'd17;
      bus.req0 = 1'b1;
      wait_gnt(got, n);
      c0 = cyc;
      sb_q.push_back('{id: 1'b0, bcd: 12'h042});
      bus.bin0 = 8'd42;
      wait_gnt(got, n);
      c1 = cyc;
      chk("b2b_spacing1", c1 - c0, BIN_W + 1);
      sb_q.push_back('{id: 1'b0, bcd: 12'h250});
      bus.bin0 = 8'd250;
      wait_gnt(got, n);
      chk("b2b_spacing2", cyc - c1, BIN_W + 1);
      bus.req0 = 1'b0;
      drain();

      // Reset mid-conversion: no done may follow (none queued)
      bus.bin0 = 8'd200;
      bus.req0 = 1'b1;
      wait_gnt(got, n);
      bus.req0 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy",    {31'd0, bus.busy},    32'd0);
      chk("abort_bcd",     {20'd0, bus.bcd_out}, 32'd0);
      chk("abort_done_id", {31'd0, bus.done_id}, 32'd0);
      rst = 1'b0;
      repeat (12) tick();
      req_one(1, 64);
      drain();

      // Simultaneous request after the abort: requester 0 first
      sb_q.push_back('{id: 1'b0, bcd: 12'h031});
      sb_q.push_back('{id: 1'b1, bcd: 12'h187});
      bus.bin0 = 8'd31;
      bus.bin1 = 8'd187;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      wait_gnt(got, n);
      chk("post_abort_gnt0", got, 0);
      bus.req0 = 1'b0;
      wait_gnt(got, n);
      chk("post_abort_gnt1", got, 1);
      bus.req1 = 1'b0;
      drain();

      // Exhaustive sweep through requester 0
      for (int v = 0; v < (1 << BIN_W); v++) req_one(0, v);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
